// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data widths, reset PC, NOP encoding,
// prefetch queue state type and a PC alignment helper.
package riscv_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam int unsigned     ILEN             = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic {
    FILL,
    DRAIN
  } ipq_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous clear; head entry is presented
// combinationally on head, clear takes priority over push/pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  always_comb begin
    head  = mem[rd_ptr];
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers in-order
// responses and flushes on redirect. Define IPQ_BYPASS_EN for a same-cycle response bypass.
module instr_prefetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ipq_state_t      state, state_next;
  logic [XLEN-1:0] fetch_pc, fetch_pc_next;
  logic [CW-1:0]   outstanding, outstanding_next;
  logic [CW-1:0]   drop_cnt, drop_cnt_next;
  logic            credit_ok, req_fire, rsp_keep, bypass;

  logic                 data_push, data_pop, data_full, data_empty;
  logic [XLEN+ILEN-1:0] data_in, data_head;
  logic [CW-1:0]        data_count;

  logic            pend_pop, pend_full, pend_empty;
  logic [XLEN-1:0] pend_head;
  logic [CW-1:0]   pend_count;

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pend_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (pend_pop),
    .head      (pend_head),
    .count     (pend_count),
    .full      (pend_full),
    .empty     (pend_empty)
  );

  sync_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .push      (data_push),
    .push_data (data_in),
    .pop       (data_pop),
    .head      (data_head),
    .count     (data_count),
    .full      (data_full),
    .empty     (data_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
    end
  end

  always_comb begin
    // Stale requests still hold credits until their responses come back.
    credit_ok     = ({1'b0, data_count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);
    mem_req_valid = rst_n && !redirect && credit_ok;
    mem_req_addr  = fetch_pc;
    req_fire      = mem_req_valid && mem_req_ready;
    rsp_keep      = mem_rsp_valid && (state == FILL) && !redirect;
`ifdef IPQ_BYPASS_EN
    bypass        = rsp_keep && data_empty;
`else
    bypass        = 1'b0;
`endif
    out_valid     = !data_empty || bypass;
    {out_pc, out_instr} = bypass ? {pend_head, mem_rsp_data} : data_head;
    data_in       = {pend_head, mem_rsp_data};
    data_push     = rsp_keep && !(bypass && out_ready);
    data_pop      = !data_empty && out_ready && !redirect;
    // Stale requests lost their pending PCs at the flush, so only kept responses pop it.
    pend_pop      = rsp_keep;

    outstanding_next = outstanding + CW'(req_fire) - CW'(mem_rsp_valid);

    fetch_pc_next = fetch_pc;
    if (redirect) begin
      fetch_pc_next = word_align(redirect_pc);
    end else if (req_fire) begin
      fetch_pc_next = fetch_pc + XLEN'(4);
    end

    drop_cnt_next = drop_cnt;
    if (redirect) begin
      drop_cnt_next = outstanding - CW'(mem_rsp_valid);
    end else if ((state == DRAIN) && mem_rsp_valid) begin
      drop_cnt_next = drop_cnt - CW'(1);
    end

    state_next = (drop_cnt_next == '0) ? FILL : DRAIN;
  end

  a_no_unsolicited_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rsp_valid |-> (outstanding != '0));
  a_no_data_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    data_push |-> !data_full);
  a_pend_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (!(pend_pop && pend_empty)) && (!(req_fire && pend_full)) &&
    (({1'b0, pend_count} + {1'b0, drop_cnt}) == {1'b0, outstanding}));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized scoreboard bench for instr_prefetch_queue with an in-order memory model.
`timescale 1ns/1ps
module tb_instr_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } mem_txn_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mem_txn_t    mem_q[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          tb_count = 0;
  int unsigned cycle = 0;
  int unsigned lat_min = 1, lat_max = 1;
  int unsigned fire_cnt = 0, pop_cnt = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic        exp_rv, exp_ov;
  exp_t        mon_e;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory presents the oldest due response at the start of each cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(mem_q[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
  endtask

  // Reference model: credit rule, output occupancy, fetch address sequence.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_rv = !redirect && ((tb_count + mem_q.size()) < DEPTH);
      check1("mem_req_valid", mem_req_valid, exp_rv);
      if (mem_req_valid) check32("mem_req_addr", mem_req_addr, exp_pc);
      exp_ov = (tb_count > 0);
`ifdef IPQ_BYPASS_EN
      if (mem_rsp_valid && mem_q.size() > 0 && !redirect) begin
        if (!mem_q[0].stale) exp_ov = 1'b1;
      end
`endif
      check1("out_valid", out_valid, exp_ov);

      if (mem_rsp_valid && mem_q.size() > 0) begin
        if (!mem_q[0].stale && !redirect) tb_count++;
        void'(mem_q.pop_front());
      end
      if (exp_ov && out_ready && !redirect) begin
        tb_count--;
        pop_cnt++;
      end
      if (redirect) begin
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        tb_count = 0;
        sb.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (mem_req_valid && mem_req_ready) begin
        mem_q.push_back('{addr: mem_req_addr, due: cycle + $urandom_range(lat_max, lat_min), stale: 1'b0});
        sb.push_back('{pc: exp_pc, instr: instr_of(exp_pc)});
        exp_pc += 32'd4;
        fire_cnt++;
      end
    end
  end

  // Monitor: every consumed output must match the oldest surviving fetch.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !redirect) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got pc %h, expected no output", out_pc);
      end else begin
        mon_e = sb.pop_front();
        check32("out_pc", out_pc, mon_e.pc);
        check32("out_instr", out_instr, mon_e.instr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned p0, f0;
    bit found;
    rst_n = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check1("rst_mem_req_valid", mem_req_valid, 1'b0);
    check32("rst_mem_req_addr", mem_req_addr, RESET_PC);
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_out_pc", out_pc, 32'h0);
    check32("rst_out_instr", out_instr, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Streaming with 1-cycle memory: full throughput once filled.
    repeat (10) step();
    p0 = pop_cnt;
    repeat (20) step();
    check32("stream_pops", p0 + 32'd20, pop_cnt);

    // Stall: exactly DEPTH requests issue, then resume.
    mem_req_ready = 1'b0;
    repeat (8) step();
    out_ready = 1'b0; mem_req_ready = 1'b1;
    f0 = fire_cnt;
    repeat (12) step();
    #2;
    check32("stall_fires", fire_cnt - f0, DEPTH);
    check1("stall_req_valid", mem_req_valid, 1'b0);
    out_ready = 1'b1;
    repeat (20) step();

    // 3-cycle memory, redirect with 3 outstanding.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (mem_q.size() == 3) found = 1'b1;
    end
    check1("c_three_outstanding", found, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      #2;
      if (out_valid) begin
        found = 1'b1;
        check32("c_first_pc", out_pc, 32'h0000_0100);
      end else step();
    end
    check1("c_output_seen", found, 1'b1);
    repeat (10) step();

    // Redirect coinciding with a response and a pop.
    lat_min = 2; lat_max = 2;
    repeat (10) step();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      #2;
      if (mem_rsp_valid && out_valid) found = 1'b1;
    end
    check1("d_rsp_and_pop", found, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    #2;
    check1("d_out_valid_after", out_valid, 1'b0);
    repeat (10) step();

    // Address wrap at the top of memory.
    lat_min = 1; lat_max = 1;
    repeat (5) step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    #2; check32("wrap_addr0", mem_req_addr, 32'hFFFF_FFF8);
    step(); #2; check32("wrap_addr1", mem_req_addr, 32'hFFFF_FFFC);
    step(); #2; check32("wrap_addr2", mem_req_addr, 32'h0000_0000);
    repeat (10) step();

    // Randomized traffic with occasional redirects.
    lat_min = 1; lat_max = 4;
    repeat (1500) begin
      step();
      mem_req_ready = ($urandom_range(3, 0) != 0);
      out_ready     = ($urandom_range(2, 0) != 0);
      redirect      = ($urandom_range(39, 0) == 0);
      redirect_pc   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
    end

    // Drain: every surviving fetch must reach the output.
    redirect = 1'b0; mem_req_ready = 1'b0; out_ready = 1'b1;
    repeat (20) step();
    check32("drain_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
